// File: rtl/sram_arbiter_2x1_pkg.sv
// sram_arbiter_2x1_pkg: shared FSM encoding, grant indices and SRAM-like size codes
package sram_arbiter_2x1_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} arb_state_t;
  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
endpackage

// File: rtl/sram_arbiter_2x1_if.sv
// sram_arbiter_2x1_if: SRAM-like port bundle; master issues req/wr/size/addr/wdata, slave returns rdata/addr_ok/data_ok
interface sram_arbiter_2x1_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;
  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_arbiter_2x1_req_mux2.sv
// sram_req_mux2: combinational 2:1 mux of an SRAM-like request bundle (sel 0 = port 0 / inst, 1 = port 1 / data)
module sram_req_mux2
  import sram_arbiter_2x1_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_sel,
  input  logic              i_req0,
  input  logic              i_wr0,
  input  logic [1:0]        i_size0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic              i_wr1,
  input  logic [1:0]        i_size1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_req,
  output logic              o_wr,
  output logic [1:0]        o_size,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata
);
  assign o_req   = i_sel == GNT_DATA ? i_req1   : i_req0;
  assign o_wr    = i_sel == GNT_DATA ? i_wr1    : i_wr0;
  assign o_size  = i_sel == GNT_DATA ? i_size1  : i_size0;
  assign o_addr  = i_sel == GNT_DATA ? i_addr1  : i_addr0;
  assign o_wdata = i_sel == GNT_DATA ? i_wdata1 : i_wdata0;
endmodule

// File: rtl/sram_arbiter_2x1.sv
// sram_arbiter_2x1: arbitrates inst/data SRAM-like ports onto one mem port, one outstanding transaction
// Ports: clk, rst (sync active-high); i_inst, i_data (slave bundles); o_mem (master bundle).
// SRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority, data over inst.
module sram_arbiter_2x1
  import sram_arbiter_2x1_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  sram_arbiter_2x1_if.slave  i_inst,
  sram_arbiter_2x1_if.slave  i_data,
  sram_arbiter_2x1_if.master o_mem
);
  arb_state_t        r_state, w_next;
  logic              r_gnt;
  logic              w_pick, w_sel;
  logic              w_req, w_wr;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_mem_req, w_aok, w_dok;
`ifdef SRAM_ARB_RR_EN
  logic r_last;
  assign w_pick = (i_inst.req & i_data.req) ? ~r_last : i_data.req;
  always_ff @(posedge clk)
    if (rst) r_last <= GNT_INST;
    else if (w_aok) r_last <= w_sel;
`else
  assign w_pick = i_data.req ? GNT_DATA : GNT_INST;
`endif
  // Arbitration only happens in IDLE; afterwards the locked grant steers everything.
  assign w_sel = r_state == IDLE ? w_pick : r_gnt;
  sram_req_mux2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .i_sel   (w_sel),
    .i_req0  (i_inst.req),
    .i_wr0   (i_inst.wr),
    .i_size0 (i_inst.size),
    .i_addr0 (i_inst.addr),
    .i_wdata0(i_inst.wdata),
    .i_req1  (i_data.req),
    .i_wr1   (i_data.wr),
    .i_size1 (i_data.size),
    .i_addr1 (i_data.addr),
    .i_wdata1(i_data.wdata),
    .o_req   (w_req),
    .o_wr    (w_wr),
    .o_size  (w_size),
    .o_addr  (w_addr),
    .o_wdata (w_wdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= GNT_INST;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_mem_req) r_gnt <= w_sel;
    end
  // mem_data_ok outside RESP is ignored, so only RESP looks at it.
  always_comb
    w_next = r_state == IDLE ? (w_mem_req ? (o_mem.addr_ok ? RESP : REQ) : IDLE) :
             r_state == REQ  ? (o_mem.addr_ok ? RESP : REQ) :
                               (o_mem.data_ok ? IDLE : RESP);
  always_comb begin
    w_mem_req      = ~rst & (r_state == IDLE ? w_req : r_state == REQ);
    w_aok          = w_mem_req & o_mem.addr_ok;
    w_dok          = ~rst & (r_state == RESP) & o_mem.data_ok;
    o_mem.req      = w_mem_req;
    o_mem.wr       = w_wr;
    o_mem.size     = w_size;
    o_mem.addr     = w_addr;
    o_mem.wdata    = w_wdata;
    i_inst.addr_ok = w_aok & (w_sel == GNT_INST);
    i_data.addr_ok = w_aok & (w_sel == GNT_DATA);
    i_inst.data_ok = w_dok & (r_gnt == GNT_INST);
    i_data.data_ok = w_dok & (r_gnt == GNT_DATA);
    i_inst.rdata   = o_mem.rdata;
    i_data.rdata   = o_mem.rdata;
  end
endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// tb_sram_arbiter_2x1: directed vector table, round-robin/priority sequence and randomized model check
module tb_sram_arbiter_2x1;
  import sram_arbiter_2x1_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  sram_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_arbiter_2x1_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();
  sram_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_inst(inst_if),
    .i_data(data_if),
    .o_mem (mem_if)
  );
  typedef struct {
    logic r, ir, dr, dw;
    logic [31:0] ia, da, wd;
    logic aok, dok;
    logic [31:0] rd;
    logic mr;
    logic [31:0] ma;
    logic mw;
    logic [31:0] mwd;
    logic iao, dao, ido, ddo;
  } vec_t;
  int n_pass = 0;
  int n_tot = 0;
  vec_t tbl[$];
  function automatic vec_t v(input logic r, ir, dr, dw, input logic [31:0] ia, da, wd,
                             input logic aok, dok, input logic [31:0] rd, input logic mr,
                             input logic [31:0] ma, input logic mw, input logic [31:0] mwd,
                             input logic iao, dao, ido, ddo);
    vec_t x;
    x.r = r; x.ir = ir; x.dr = dr; x.dw = dw; x.ia = ia; x.da = da; x.wd = wd;
    x.aok = aok; x.dok = dok; x.rd = rd; x.mr = mr; x.ma = ma; x.mw = mw; x.mwd = mwd;
    x.iao = iao; x.dao = dao; x.ido = ido; x.ddo = ddo;
    return x;
  endfunction
  task automatic chk(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", t, act, exp);
  endtask
  task automatic drv(input logic r, ir, dr, iw, dw, input logic [1:0] isz, dsz,
                     input logic [31:0] ia, da, iwd, dwd, input logic aok, dok,
                     input logic [31:0] rd);
    rst = r;
    inst_if.req = ir; inst_if.wr = iw; inst_if.size = isz; inst_if.addr = ia; inst_if.wdata = iwd;
    data_if.req = dr; data_if.wr = dw; data_if.size = dsz; data_if.addr = da; data_if.wdata = dwd;
    mem_if.addr_ok = aok; mem_if.data_ok = dok; mem_if.rdata = rd;
  endtask
  task automatic expect_out(input string t, input logic emr, input logic [31:0] ema,
                            input logic emw, input logic [1:0] esz, input logic [31:0] ewd,
                            input logic eiao, edao, eido, eddo, input logic [31:0] erd);
    chk({t, " mem_req"}, 32'(mem_if.req), 32'(emr));
    if (emr) begin
      chk({t, " mem_addr"}, mem_if.addr, ema);
      chk({t, " mem_wr"}, 32'(mem_if.wr), 32'(emw));
      chk({t, " mem_size"}, 32'(mem_if.size), 32'(esz));
      if (emw) chk({t, " mem_wdata"}, mem_if.wdata, ewd);
    end
    chk({t, " inst_addr_ok"}, 32'(inst_if.addr_ok), 32'(eiao));
    chk({t, " data_addr_ok"}, 32'(data_if.addr_ok), 32'(edao));
    chk({t, " inst_data_ok"}, 32'(inst_if.data_ok), 32'(eido));
    chk({t, " data_data_ok"}, 32'(data_if.data_ok), 32'(eddo));
    if (eido) chk({t, " inst_rdata"}, inst_if.rdata, erd);
    if (eddo) chk({t, " data_rdata"}, data_if.rdata, erd);
  endtask
  function automatic logic winner(input logic ir, dr, last);
`ifdef SRAM_ARB_RR_EN
    return (ir & dr) ? ~last : dr;
`else
    return dr;
`endif
  endfunction
  initial begin
    logic g;
    logic [31:0] a;
    logic busy, acc, own, last, w, emr, aok, dok, any;
    logic [31:0] rd;
    logic pr[2], pw[2], eao[2], edo[2];
    logic [1:0] psz[2];
    logic [31:0] pa[2], pwd[2];
    drv(1, 0, 0, 0, 0, SZ_W, SZ_W, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(v(1,1,0,0,32'hBFC00000,0,0,1,0,0,            0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,1,0,0,32'hBFC00000,0,0,1,0,0,            1,32'hBFC00000,0,0,         1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,                        0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,                        0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,1,32'h3C1D8000,             0,0,0,0,                    0,0,1,0));
    tbl.push_back(v(0,1,1,1,32'h1000,32'h2000,32'hDEADBEEF,1,0,0, 1,32'h2000,1,32'hDEADBEEF, 0,1,0,0));
    tbl.push_back(v(0,1,0,0,32'h1000,0,0,1,0,0,                 0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,1,0,0,32'h1000,0,0,1,1,32'hCAFEF00D,      0,0,0,0,                    0,0,0,1));
    tbl.push_back(v(0,1,0,0,32'h1000,0,0,1,0,0,                 1,32'h1000,0,0,             1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,32'h12345678,             0,0,0,0,                    0,0,1,0));
    tbl.push_back(v(0,1,0,0,32'h1000,0,0,0,0,0,                 1,32'h1000,0,0,             0,0,0,0));
    tbl.push_back(v(0,1,0,0,32'h1000,0,0,0,0,0,                 1,32'h1000,0,0,             0,0,0,0));
    tbl.push_back(v(0,1,1,1,32'h1000,32'h2000,32'h55AA55AA,0,0,0, 1,32'h1000,0,0,           0,0,0,0));
    tbl.push_back(v(0,1,1,1,32'h1000,32'h2000,32'h55AA55AA,0,0,0, 1,32'h1000,0,0,           0,0,0,0));
    tbl.push_back(v(0,1,1,1,32'h1000,32'h2000,32'h55AA55AA,1,0,0, 1,32'h1000,0,0,           1,0,0,0));
    tbl.push_back(v(0,0,1,1,0,32'h2000,32'h55AA55AA,1,1,32'hAAAA5555, 0,0,0,0,              0,0,1,0));
    tbl.push_back(v(0,0,1,1,0,32'h2000,32'h55AA55AA,1,0,0,      1,32'h2000,1,32'h55AA55AA,  0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,                        0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,32'h11111111,             0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,32'h22222222,             0,0,0,0,                    0,0,0,0));
    tbl.push_back(v(0,1,0,0,32'hBFC00000,0,0,1,0,0,            1,32'hBFC00000,0,0,         1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,32'h3C1D8000,             0,0,0,0,                    0,0,1,0));
    foreach (tbl[i]) begin
      @(negedge clk);
      drv(tbl[i].r, tbl[i].ir, tbl[i].dr, 1'b0, tbl[i].dw, SZ_W, SZ_W, tbl[i].ia, tbl[i].da,
          32'h0, tbl[i].wd, tbl[i].aok, tbl[i].dok, tbl[i].rd);
      #1;
      expect_out($sformatf("vec%0d", i), tbl[i].mr, tbl[i].ma, tbl[i].mw, SZ_W, tbl[i].mwd,
                 tbl[i].iao, tbl[i].dao, tbl[i].ido, tbl[i].ddo, tbl[i].rd);
    end
    @(negedge clk);
    drv(1, 0, 0, 0, 0, SZ_W, SZ_W, 0, 0, 0, 0, 0, 0, 0);
    #1;
    expect_out("arb_rst", 0, 0, 0, SZ_W, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
`ifdef SRAM_ARB_RR_EN
      g = (k % 2 == 0);
`else
      g = 1'b1;
`endif
      a = g ? 32'h2000 + 32'(k) : 32'h1000 + 32'(k);
      @(negedge clk);
      drv(0, 1, 1, 0, 1, SZ_W, SZ_W, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 0, 32'h5000 + 32'(k), 1, 0, 0);
      #1;
      expect_out($sformatf("arb%0d_acc", k), 1, a, g, SZ_W, 32'h5000 + 32'(k), ~g, g, 0, 0, 0);
      @(negedge clk);
      drv(0, 1, 1, 0, 1, SZ_W, SZ_W, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 0, 32'h5000 + 32'(k), 1, 1, 32'(k));
      #1;
      expect_out($sformatf("arb%0d_resp", k), 0, 0, 0, SZ_W, 0, 0, 0, ~g, g, 32'(k));
    end
    @(negedge clk);
    drv(1, 0, 0, 0, 0, SZ_W, SZ_W, 0, 0, 0, 0, 0, 0, 0);
    busy = 0; acc = 0; own = 0; last = 0;
    for (int p = 0; p < 2; p++) begin
      pr[p] = 0; pw[p] = 0; psz[p] = SZ_W; pa[p] = 0; pwd[p] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (!pr[p] && $urandom_range(0, 2) == 0) begin
          pr[p] = 1; pw[p] = 1'($urandom); psz[p] = 2'($urandom_range(0, 2));
          pa[p] = $urandom; pwd[p] = $urandom;
        end
      aok = 1'($urandom);
      rd = $urandom;
      dok = (busy && acc) ? ($urandom_range(0, 2) == 0) : (!aok && $urandom_range(0, 4) == 0);
      drv(0, pr[0], pr[1], pw[0], pw[1], psz[0], psz[1], pa[0], pa[1], pwd[0], pwd[1], aok, dok, rd);
      #1;
      any = pr[0] | pr[1];
      w = busy ? own : winner(pr[0], pr[1], last);
      emr = busy ? !acc : any;
      eao[0] = 0; eao[1] = 0; edo[0] = 0; edo[1] = 0;
      if (emr && aok) eao[w] = 1;
      if (busy && acc && dok) edo[own] = 1;
      expect_out($sformatf("rnd%0d", c), emr, pa[w], pw[w], psz[w], pwd[w],
                 eao[0], eao[1], edo[0], edo[1], rd);
      if (!busy && any) begin
        busy = 1; own = w; acc = aok;
      end else if (busy && !acc && aok) acc = 1;
      else if (busy && acc && dok) busy = 0;
      if (emr && aok) last = w;
      for (int p = 0; p < 2; p++) if (eao[p]) pr[p] = 0;
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sram_arbiter_2x1.md
# sram_arbiter_2x1

Arbitrates two SRAM-like requesters, the instruction-side (`inst_*`) and data-side (`data_*`) cache miss/uncached ports, onto one SRAM-like master port (`mem_*`) that feeds the single AXI bridge.

- Allows exactly one outstanding transaction.
- The grant is locked from address acceptance until the matching `data_ok`.
- Response data and `data_ok` are routed back only to the granted requester.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: read/write data width.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `inst_req`, `data_req`, in, 1 each: request valid. Held by the requester until its `addr_ok`.
- `inst_wr`, `data_wr`, in, 1 each: 1 = write, 0 = read.
- `inst_size`, `data_size`, in, 2 each: access size, 0/1/2 = byte/half/word.
- `inst_addr`, `data_addr`, in, `ADDR_W` each: physical address.
- `inst_wdata`, `data_wdata`, in, `DATA_W` each: write data.
- `inst_rdata`, `data_rdata`, out, `DATA_W` each: read data, valid with the matching `data_ok`.
- `inst_addr_ok`, `data_addr_ok`, out, 1 each: request accepted.
- `inst_data_ok`, `data_data_ok`, out, 1 each: transaction complete.
- `mem_req`, `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`, out: forwarded request fields.
- `mem_rdata` in, `DATA_W`; `mem_addr_ok` in, 1; `mem_data_ok` in, 1: downstream responses.

## Operation
State machine: IDLE, REQ, RESP. The 1-bit register `gnt` holds the locked grant (0 = inst, 1 = data).

IDLE:
- `sel` is computed combinationally from the current requests. Default rule: data port wins when both request.
- `mem_req = inst_req | data_req`. All `mem_*` fields come from `sel`.
- `sel_addr_ok = mem_addr_ok`.
- On `mem_req & mem_addr_ok`: `gnt <= sel`, go to RESP.
- On `mem_req & ~mem_addr_ok`: `gnt <= sel`, go to REQ.

REQ:
- `mem_req = 1`, with fields muxed from `gnt`. A higher-priority request arriving now does not preempt.
- The granted port's `addr_ok = mem_addr_ok`.
- On `mem_addr_ok`, go to RESP.

RESP:
- `mem_req = 0`. The other port is stalled, with its `addr_ok = 0`.
- `gnt_data_ok = mem_data_ok` and `gnt_rdata = mem_rdata`.
- On `mem_data_ok`, go to IDLE.

Common rules:
- The non-granted `addr_ok` and `data_ok` are 0 in every state.
- Both `rdata` outputs may simply mirror `mem_rdata`. They are only meaningful with `data_ok`.
- Writes follow the same path. `data_ok` acknowledges write completion and `rdata` is don't-care.
- A `mem_data_ok` arriving in IDLE or REQ is a protocol violation. It is ignored: no upstream `data_ok` and no state change.

## Timing
- Reset: state = IDLE, `gnt = 0`. While `rst` is high, `mem_req` and all `addr_ok`/`data_ok` outputs are forced to 0.
- Reset mid-transaction drops the transaction silently. The downstream bridge shares the same reset.
- Request path is zero-latency combinational: upstream `req` → `mem_req` and `mem_addr_ok` → upstream `addr_ok` in the same cycle.
- Response path is zero-latency: `mem_data_ok` → upstream `data_ok` in the same cycle.
- Best-case throughput is one transaction per 2 cycles:
  - cycle 0: IDLE, `addr_ok`;
  - cycle ≥1: RESP, `data_ok`;
  - next cycle: IDLE, next arbitration.
- `data_ok` and a new `req` in the same RESP cycle: the new `req` is not accepted until the following IDLE cycle.
- `mem_data_ok` in the same cycle as `mem_addr_ok` is unsupported. The bridge never returns data in the acceptance cycle.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Round-robin arbitration, with an extra 1-bit `last` register (reset 0) recording the most recent grant.
  - When both requesters are active in IDLE, `sel = ~last`.
  - `last` updates on each address acceptance.
  - A single requester always wins.
- `SRAM_ARB_RR_EN` undefined: fixed priority, data over inst, with no `last` register.

## Structure
- Shared package:
  - state encoding typedef `arb_state_t` (IDLE=0, REQ=1, RESP=2);
  - grant constants `GNT_INST=0`, `GNT_DATA=1`;
  - SRAM-like size constants `SZ_B/SZ_H/SZ_W`.
- One natural sub-module, `sram_req_mux2`: a purely combinational 2:1 mux of the `req`/`wr`/`size`/`addr`/`wdata` bundle, indexed by select.
- The FSM, `gnt`, and response routing live in the top.

## Test plan
1. Inst-only read, `inst_addr=0xBFC00000`, `mem_addr_ok` held 1, `mem_data_ok` 3 cycles later with `rdata=0x3C1D8000`:
   - `inst_addr_ok` at cycle 0;
   - `inst_data_ok` with `0x3C1D8000` at cycle 3;
   - `data_*` outputs stay 0.
2. Simultaneous inst read `0x1000` and data write `0x2000`/`0xDEADBEEF`, size 2:
   - data granted first (fixed priority);
   - `mem_addr=0x2000`, `mem_wr=1`, `mem_wdata=0xDEADBEEF`;
   - inst is accepted only in the IDLE cycle after `data_data_ok`.
3. `mem_addr_ok` held low 4 cycles while inst is pending; `data_req` rises in cycle 2:
   - grant stays inst;
   - `mem_addr` stays `0x1000` throughout;
   - `data_addr_ok` stays 0.
4. With `SRAM_ARB_RR_EN`, both ports request continuously for 6 transactions:
   - grants alternate data, inst, data, inst, data, inst;
   - without the macro, all 6 go to data.
5. `rst` asserted in RESP before `mem_data_ok`:
   - next cycle state is IDLE, `mem_req=0`;
   - a later spurious `mem_data_ok` produces no upstream `data_ok`.
6. `mem_data_ok` pulsed while in IDLE with no requests: no `data_ok` on either port, state unchanged.
